// File: rtl/calc2_port_master.sv
// calc2_port_master
// Initiator for one calc2 request/response port. Whole operations arrive on
// a valid/ready command interface and are serialised into the two-cycle
// calc2 request (op+operand1, then operand2). Each operation gets the
// lowest free 2-bit tag. Returning responses are matched by tag. Unanswered
// tags are retired as timeouts. Results wait in a 4-deep FIFO.
//
// Ports:
//   c_clk, reset          clock (rising edge), async active-high reset
//   cmd_valid/cmd_ready   operation handshake; cmd_op, cmd_d1, cmd_d2 payload
//   req_cmd_out/req_data_out/req_tag_out   registered request to calc2
//   out_resp/out_data/out_tag              response from calc2
//   res_valid/res_ready   result handshake; res_resp, res_data, res_tag payload
//   outstanding           number of issued, unretired tags (0..4)
//   spurious_err          sticky flag: response for a tag that was not outstanding
module calc2_port_master #(
  parameter int TIMEOUT = 16,
  parameter int TW      = 8
) (
  input  logic        c_clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [3:0]  cmd_op,
  input  logic [31:0] cmd_d1,
  input  logic [31:0] cmd_d2,
  output logic [3:0]  req_cmd_out,
  output logic [31:0] req_data_out,
  output logic [1:0]  req_tag_out,
  input  logic [1:0]  out_resp,
  input  logic [31:0] out_data,
  input  logic [1:0]  out_tag,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [1:0]  res_resp,
  output logic [31:0] res_data,
  output logic [1:0]  res_tag,
  output logic [2:0]  outstanding,
  output logic        spurious_err
);

  typedef enum logic [1:0] {IDLE = 2'd0, OP1 = 2'd1, OP2 = 2'd2} state_t;

  state_t        state, state_nxt;
  logic [3:0]    req_cmd_nxt;
  logic [31:0]   req_data_nxt;
  logic [1:0]    req_tag_nxt;
  logic          accept;
  logic [1:0]    cur_tag;
  logic [31:0]   d2_q;

  logic [3:0]    tag_busy;
  logic [TW-1:0] tmr [4];
  logic [2:0]    busy_cnt;
  logic [1:0]    free_tag;

  logic          rsp_valid;
  logic          rsp_hit;
  logic [3:0]    expired;
  logic          retire;
  logic [1:0]    retire_tag;
  logic [3:0]    free_vec;
  logic          push;
  logic          pop;
  logic [35:0]   push_entry;

  logic [35:0]   fifo_mem [4];
  logic [1:0]    wr_ptr, rd_ptr;
  logic [2:0]    fifo_cnt;

  // Tag bookkeeping: how many tags are in flight and which one to hand out
  // next. A tag freed this cycle still reads as busy here. It can be
  // allocated again only from the next cycle.
  always_comb begin
    busy_cnt = 3'(tag_busy[0]) + 3'(tag_busy[1]) + 3'(tag_busy[2]) + 3'(tag_busy[3]);
    free_tag = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!tag_busy[i]) free_tag = 2'(i);
    end
  end

  // Every buffered result came from an outstanding tag. Limiting the sum to
  // 4 therefore guarantees the FIFO cannot overflow.
  assign cmd_ready = (state == IDLE) && (tag_busy != 4'hF) &&
                     ((4'(busy_cnt) + 4'(fifo_cnt)) < 4'd4);
  assign outstanding = busy_cnt;

  // Request sequencer: next state and next values of the registered
  // request outputs.
  always_comb begin
    state_nxt    = state;
    req_cmd_nxt  = 4'd0;
    req_data_nxt = 32'd0;
    req_tag_nxt  = 2'd0;
    accept       = 1'b0;
    case (state)
      IDLE: begin
        if (cmd_valid && cmd_ready) begin
          accept       = 1'b1;
          state_nxt    = OP1;
          req_cmd_nxt  = cmd_op;
          req_data_nxt = cmd_d1;
          req_tag_nxt  = free_tag;
        end
      end
      OP1: begin
        state_nxt    = OP2;
        req_data_nxt = d2_q;
      end
      OP2: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register and registered request outputs. Operand2 and the tag are
  // held until the OP1/OP2 cycles need them.
  always_ff @(posedge c_clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      req_cmd_out  <= 4'd0;
      req_data_out <= 32'd0;
      req_tag_out  <= 2'd0;
      cur_tag      <= 2'd0;
      d2_q         <= 32'd0;
    end else begin
      state        <= state_nxt;
      req_cmd_out  <= req_cmd_nxt;
      req_data_out <= req_data_nxt;
      req_tag_out  <= req_tag_nxt;
      if (accept) begin
        cur_tag <= free_tag;
        d2_q    <= cmd_d2;
      end
    end
  end

  // Response matching and timeout retirement. A real response always takes
  // the single push slot. An expired tag waits for a cycle with no response.
  always_comb begin
    rsp_valid  = (out_resp != 2'd0);
    rsp_hit    = rsp_valid && tag_busy[out_tag];
    retire_tag = 2'd0;
    for (int i = 0; i < 4; i++) begin
      expired[i] = tag_busy[i] && (tmr[i] == '0);
    end
    for (int i = 3; i >= 0; i--) begin
      if (expired[i]) retire_tag = 2'(i);
    end
    retire     = !rsp_hit && (expired != 4'd0);
    free_vec   = 4'd0;
    push_entry = {2'd3, 32'd0, retire_tag};
    if (rsp_hit) begin
      free_vec[out_tag] = 1'b1;
      push_entry        = {out_resp, out_data, out_tag};
    end else if (retire) begin
      free_vec[retire_tag] = 1'b1;
    end
    push = rsp_hit || retire;
  end

  // Outstanding mask, per-tag timers and the sticky spurious flag. A tag
  // becomes outstanding at the end of its OP2 cycle. Before then, any
  // response carrying it counts as spurious.
  always_ff @(posedge c_clk or posedge reset) begin
    if (reset) begin
      tag_busy     <= 4'd0;
      spurious_err <= 1'b0;
      for (int i = 0; i < 4; i++) tmr[i] <= '0;
    end else begin
      tag_busy <= (tag_busy & ~free_vec) |
                  ((state == OP2) ? (4'b0001 << cur_tag) : 4'b0000);
      for (int i = 0; i < 4; i++) begin
        if ((state == OP2) && (cur_tag == 2'(i))) begin
          tmr[i] <= TW'(TIMEOUT);
        end else if (tag_busy[i] && (tmr[i] != '0)) begin
          tmr[i] <= tmr[i] - TW'(1);
        end
      end
      if (rsp_valid && !tag_busy[out_tag]) spurious_err <= 1'b1;
    end
  end

  // Result FIFO pointers and occupancy. A push and a pop in the same cycle
  // are both honoured.
  assign pop = res_valid && res_ready;

  always_ff @(posedge c_clk or posedge reset) begin
    if (reset) begin
      wr_ptr   <= 2'd0;
      rd_ptr   <= 2'd0;
      fifo_cnt <= 3'd0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 2'd1;
      if (pop)  rd_ptr <= rd_ptr + 2'd1;
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 3'd1;
        2'b01:   fifo_cnt <= fifo_cnt - 3'd1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  // FIFO storage has no reset. The outputs are gated while the FIFO is
  // empty, so stale contents never show.
  always_ff @(posedge c_clk) begin
    if (push) fifo_mem[wr_ptr] <= push_entry;
  end

  assign res_valid = (fifo_cnt != 3'd0);
  assign {res_resp, res_data, res_tag} = res_valid ? fifo_mem[rd_ptr] : 36'd0;

endmodule

// File: tb/tb_calc2_port_master.sv
// tb_calc2_port_master
// Self-checking bench for calc2_port_master. Inputs are applied one cycle at
// a time. A transaction-level model predicts every output for the next
// cycle. The model keeps live tags with deadline cycle numbers, a result
// queue and the issue cycle of the current operation.
module tb_calc2_port_master;

  localparam int TIMEOUT = 16;
  localparam int TW      = 8;

  logic        c_clk = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [3:0]  cmd_op;
  logic [31:0] cmd_d1;
  logic [31:0] cmd_d2;
  logic [3:0]  req_cmd_out;
  logic [31:0] req_data_out;
  logic [1:0]  req_tag_out;
  logic [1:0]  out_resp;
  logic [31:0] out_data;
  logic [1:0]  out_tag;
  logic        res_valid;
  logic        res_ready;
  logic [1:0]  res_resp;
  logic [31:0] res_data;
  logic [1:0]  res_tag;
  logic [2:0]  outstanding;
  logic        spurious_err;

  calc2_port_master #(.TIMEOUT(TIMEOUT), .TW(TW)) dut (
    .c_clk(c_clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_d1(cmd_d1), .cmd_d2(cmd_d2),
    .req_cmd_out(req_cmd_out), .req_data_out(req_data_out), .req_tag_out(req_tag_out),
    .out_resp(out_resp), .out_data(out_data), .out_tag(out_tag),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_resp(res_resp), .res_data(res_data), .res_tag(res_tag),
    .outstanding(outstanding), .spurious_err(spurious_err)
  );

  always #5 c_clk = ~c_clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Reference model state
  bit          m_live [4];
  int          m_deadline [4];
  logic [35:0] m_q [$];
  bit          m_spur;
  int          m_acc;
  int          m_idle_from;
  logic [3:0]  m_op;
  logic [31:0] m_d1, m_d2;
  logic [1:0]  m_tag;
  bit          m_accepted;

  function automatic int liveCount();
    int n = 0;
    for (int i = 0; i < 4; i++) if (m_live[i]) n++;
    return n;
  endfunction

  function automatic bit modelReady();
    return (cyc >= m_idle_from) && ((liveCount() + m_q.size()) < 4);
  endfunction

  task automatic modelReset();
    for (int i = 0; i < 4; i++) begin
      m_live[i]     = 1'b0;
      m_deadline[i] = 0;
    end
    m_q.delete();
    m_spur      = 1'b0;
    m_acc       = -100;
    m_idle_from = 0;
    m_accepted  = 1'b0;
  endtask

  task automatic checkOutput(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s cyc=%0d got=%0h expected=%0h", name, cyc, obs, exp);
    end
  endtask

  // Compare every output against what the model says this cycle shows
  task automatic checkAll();
    logic [3:0]  ecmd = 4'd0;
    logic [31:0] edata = 32'd0;
    logic [1:0]  etag = 2'd0;
    logic [35:0] head = 36'd0;
    if (cyc == m_acc + 1) begin
      ecmd = m_op; edata = m_d1; etag = m_tag;
    end else if (cyc == m_acc + 2) begin
      edata = m_d2;
    end
    if (m_q.size() > 0) head = m_q[0];
    checkOutput("req_cmd", 64'(req_cmd_out), 64'(ecmd));
    checkOutput("req_data", 64'(req_data_out), 64'(edata));
    checkOutput("req_tag", 64'(req_tag_out), 64'(etag));
    checkOutput("cmd_ready", 64'(cmd_ready), 64'(modelReady()));
    checkOutput("res_valid", 64'(res_valid), 64'(m_q.size() != 0));
    checkOutput("res_resp", 64'(res_resp), 64'(head[35:34]));
    checkOutput("res_data", 64'(res_data), 64'(head[33:2]));
    checkOutput("res_tag", 64'(res_tag), 64'(head[1:0]));
    checkOutput("outstanding", 64'(outstanding), 64'(liveCount()));
    checkOutput("spurious", 64'(spurious_err), 64'(m_spur));
  endtask

  // Drive one cycle of inputs, advance the model through that cycle, then
  // check the outputs after the clock edge
  task automatic applyStimulus(input bit v, input logic [3:0] op, input logic [31:0] d1,
                               input logic [31:0] d2, input logic [1:0] resp,
                               input logic [31:0] odata, input logic [1:0] otag,
                               input bit rready);
    bit rdy;
    bit live_before [4];
    cmd_valid = v;   cmd_op = op;     cmd_d1 = d1;   cmd_d2 = d2;
    out_resp  = resp; out_data = odata; out_tag = otag; res_ready = rready;

    rdy = modelReady();
    live_before = m_live;
    m_accepted = 1'b0;
    if (m_q.size() > 0 && rready) void'(m_q.pop_front());
    if (resp != 2'd0) begin
      if (m_live[otag]) begin
        m_q.push_back({resp, odata, otag});
        m_live[otag] = 1'b0;
      end else begin
        m_spur = 1'b1;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (m_live[i] && cyc >= m_deadline[i]) begin
          m_q.push_back({2'd3, 32'd0, 2'(i)});
          m_live[i] = 1'b0;
          break;
        end
      end
    end
    if (cyc == m_acc + 2) begin
      m_live[m_tag]     = 1'b1;
      m_deadline[m_tag] = cyc + TIMEOUT + 1;
    end
    if (v && rdy) begin
      for (int i = 3; i >= 0; i--) if (!live_before[i]) m_tag = 2'(i);
      m_op = op; m_d1 = d1; m_d2 = d2;
      m_acc = cyc;
      m_idle_from = cyc + 3;
      m_accepted = 1'b1;
    end

    @(posedge c_clk);
    #1;
    cyc++;
    checkAll();
  endtask

  task automatic idleCycles(input int n, input bit rready);
    for (int k = 0; k < n; k++) applyStimulus(1'b0, 4'd0, 32'd0, 32'd0, 2'd0, 32'd0, 2'd0, rready);
  endtask

  // Offer an operation until it is accepted, within a bounded wait
  task automatic sendOp(input logic [3:0] op, input logic [31:0] d1, input logic [31:0] d2,
                        input bit rready);
    for (int k = 0; k < 60; k++) begin
      applyStimulus(1'b1, op, d1, d2, 2'd0, 32'd0, 2'd0, rready);
      if (m_accepted) return;
    end
    checkOutput("accept_wait", 64'd0, 64'd1);
  endtask

  // Assert reset asynchronously and check that outputs clear before any
  // clock edge, then release on the usual sampling point
  task automatic doReset();
    cmd_valid = 1'b0; cmd_op = 4'd0; cmd_d1 = 32'd0; cmd_d2 = 32'd0;
    out_resp = 2'd0; out_data = 32'd0; out_tag = 2'd0; res_ready = 1'b0;
    reset = 1'b1;
    #2;
    checkOutput("rst_req_cmd", 64'(req_cmd_out), 64'd0);
    checkOutput("rst_req_data", 64'(req_data_out), 64'd0);
    checkOutput("rst_req_tag", 64'(req_tag_out), 64'd0);
    checkOutput("rst_outstanding", 64'(outstanding), 64'd0);
    checkOutput("rst_res_valid", 64'(res_valid), 64'd0);
    checkOutput("rst_spurious", 64'(spurious_err), 64'd0);
    repeat (2) @(posedge c_clk);
    #1;
    reset = 1'b0;
    modelReset();
    checkAll();
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [3:0] ops [6];
    int acc_a;
    int lv [$];
    int r;
    logic [1:0] rsp, rtg;
    ops[0] = 4'd1; ops[1] = 4'd2; ops[2] = 4'd5; ops[3] = 4'd6; ops[4] = 4'd0; ops[5] = 4'd15;
    reset = 1'b0;
    #1;
    doReset();

    // Add 0x30 + 0x20, answered four cycles after the operand2 cycle
    sendOp(4'd1, 32'h30, 32'h20, 1'b1);
    idleCycles(5, 1'b1);
    applyStimulus(1'b0, 4'd0, 32'd0, 32'd0, 2'd1, 32'h50, 2'd0, 1'b0);
    checkOutput("add_res_data", 64'(res_data), 64'h50);
    checkOutput("add_outstanding", 64'(outstanding), 64'd0);
    idleCycles(2, 1'b1);

    // Add overflowing, answered with resp=2
    sendOp(4'd1, 32'hFFFF_FFFF, 32'h1, 1'b1);
    idleCycles(4, 1'b1);
    applyStimulus(1'b0, 4'd0, 32'd0, 32'd0, 2'd2, 32'h0, 2'd0, 1'b0);
    checkOutput("ovf_res_resp", 64'(res_resp), 64'd2);
    idleCycles(2, 1'b1);

    // Four back-to-back ops, none answered: all four time out in tag order
    for (int k = 0; k < 4; k++) sendOp(4'd2, 32'(k + 10), 32'(k), 1'b1);
    idleCycles(2, 1'b1);
    checkOutput("four_cmd_ready", 64'(cmd_ready), 64'd0);
    idleCycles(TIMEOUT + 12, 1'b1);
    checkOutput("four_drained", 64'(outstanding), 64'd0);

    // Spurious response with nothing outstanding
    applyStimulus(1'b0, 4'd0, 32'd0, 32'd0, 2'd1, 32'h1234, 2'd2, 1'b1);
    checkOutput("spur_flag", 64'(spurious_err), 64'd1);
    idleCycles(2, 1'b1);

    // Tag1 answered in the same cycle tag0 expires, results held
    doReset();
    sendOp(4'd5, 32'h1, 32'h4, 1'b0);
    acc_a = m_acc;
    sendOp(4'd6, 32'h80, 32'h2, 1'b0);
    while (cyc < acc_a + TIMEOUT + 3) idleCycles(1, 1'b0);
    applyStimulus(1'b0, 4'd0, 32'd0, 32'd0, 2'd1, 32'h8, 2'd1, 1'b0);
    checkOutput("sim_first_tag", 64'(res_tag), 64'd1);
    idleCycles(1, 1'b0);
    idleCycles(2, 1'b0);
    idleCycles(4, 1'b1);

    // Reset during OP1 with another tag already outstanding
    sendOp(4'd1, 32'h7, 32'h8, 1'b1);
    idleCycles(2, 1'b1);
    sendOp(4'd2, 32'h9, 32'h3, 1'b1);
    doReset();
    sendOp(4'd6, 32'hA5, 32'h1, 1'b1);
    checkOutput("post_rst_tag", 64'(req_tag_out), 64'd0);
    idleCycles(2, 1'b1);

    // Randomised traffic
    doReset();
    for (int k = 0; k < 900; k++) begin
      lv.delete();
      for (int i = 0; i < 4; i++) if (m_live[i]) lv.push_back(i);
      r = int'($urandom_range(0, 99));
      rsp = 2'd0;
      rtg = 2'd0;
      if (r < 30 && lv.size() > 0) begin
        rsp = 2'($urandom_range(1, 2));
        rtg = 2'(lv[$urandom_range(0, lv.size() - 1)]);
      end else if (r < 32) begin
        rsp = 2'd1;
        rtg = 2'($urandom_range(0, 3));
      end
      applyStimulus(1'($urandom_range(0, 1)), ops[$urandom_range(0, 5)], $urandom, $urandom,
                    rsp, $urandom, rtg, ($urandom_range(0, 9) < 7));
    end
    idleCycles(TIMEOUT + 10, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/calc2_port_master.md
Name: calc2_port_master

Overview:
- Hardware initiator for one calc2 request/response port (cmd/data/tag in, resp/data/tag out).
- Takes whole operations (cmd, operand1, operand2) over a valid/ready interface.
- Serialises each operation into the calc2 two-cycle request protocol and allocates a free 2-bit tag for it.
- Matches returning responses by tag, applies a per-tag timeout, and queues completed results in a 4-deep buffer with valid/ready output. Sits between bench or system logic and one calc2_top port.

Parameters:
- TIMEOUT, 16, cycles after the operand2 cycle before an unanswered tag is retired as timed out (range 2..255).
- TW, 8, width of each per-tag timeout counter.

Ports:
- c_clk  in  1  clock; all state on rising edge
- reset  in  1  asynchronous, active-high reset
- cmd_valid  in  1  operation offered
- cmd_ready  out  1  operation accepted when valid&ready
- cmd_op  in  4  calc2 command (1 add, 2 sub, 5 shl, 6 shr; others passed through)
- cmd_d1  in  32  operand1
- cmd_d2  in  32  operand2
- req_cmd_out  out  4  to calc2 reqN_cmd_in
- req_data_out  out  32  to calc2 reqN_data_in
- req_tag_out  out  2  to calc2 reqN_tag_in
- out_resp  in  2  from calc2: 0 none, 1 success, 2 overflow/underflow/invalid
- out_data  in  32  from calc2 result
- out_tag  in  2  from calc2 response tag
- res_valid  out  1  result available
- res_ready  in  1  result consumed when valid&ready
- res_resp  out  2  1/2 as returned by calc2; 3 = timeout
- res_data  out  32  result data (0 on timeout)
- res_tag  out  2  tag of result
- outstanding  out  3  tags issued and not yet retired (0..4)
- spurious_err  out  1  sticky: response seen for a non-outstanding tag

Behaviour:
- Reset (async, immediate): FSM=IDLE; all req_* outputs 0; res_valid=0; res_* = 0; outstanding=0; spurious_err=0; all tags free; buffer empty; counters 0.
- FSM states: IDLE, OP1, OP2. All req_* outputs are registered.
- IDLE:
  - req_* = 0.
  - cmd_ready=1 iff a free tag exists and (outstanding + buffer_count) < 4. This is computed from registered state only.
  - On valid&ready: latch op, d1, d2; allocate the lowest-numbered free tag; go to OP1.
- OP1: req_cmd_out=op, req_data_out=d1, req_tag_out=tag; cmd_ready=0; go to OP2.
- OP2: req_cmd_out=0, req_data_out=d2, req_tag_out=0; cmd_ready=0; mark tag outstanding; load its counter with TIMEOUT; go to IDLE.
- Issue rate: one operation per 3 cycles. Accept in cycle N, OP1 in N+1, OP2 in N+2, cmd_ready may be high again in N+3.
- Response capture (every cycle, any state):
  - If out_resp!=0 and out_tag is outstanding: push {out_resp, out_data, out_tag} into the buffer, free the tag, outstanding decrements.
  - If out_resp!=0 and the tag is not outstanding (including the tag currently in OP1/OP2): no push; spurious_err<=1 (cleared only by reset).
- Timeout:
  - Each outstanding tag's counter decrements per cycle and saturates at 0.
  - Tag is expired when its counter=0.
  - In a cycle with no valid response push, the lowest-numbered expired tag is retired: push {3, 0, tag}, free the tag. Only one retire per cycle; others wait.
  - A response for an expired but not-yet-retired tag is accepted normally (response wins).
- Buffer: 4-entry FIFO, one push max per cycle.
  - res_* show the head entry; res_valid = not empty.
  - Pop on res_valid&res_ready. Push and pop in the same cycle are both honoured.
  - Overflow cannot occur by the cmd_ready rule.
- A freed tag is not reallocated in the same cycle it is freed; it is allocatable from the next cycle.
- Reset mid-operation aborts the sequence: outputs return to 0 immediately, and in-flight tags are forgotten.

Test Plan:
- Add 0x30+0x20, stub returns resp=1, data=0x50, tag=0 four cycles after OP2 -> OP1 drives cmd=1/data=0x30/tag=0, OP2 drives cmd=0/data=0x20; res_valid with resp=1, data=0x50, tag=0; outstanding 1→0.
- Add 0xFFFFFFFF+0x1, stub returns resp=2 -> result resp=2, tag=0.
- Four ops back-to-back with no responses and res_ready=1:
  - tags 0,1,2,3 issued at 3-cycle spacing; cmd_ready=0 after the fourth accept.
  - tag0 retires with resp=3, data=0 at TIMEOUT cycles after its OP2; then tags 1,2,3 in order; cmd_ready returns.
- Spurious response resp=1, tag=2 while no tag is outstanding -> spurious_err=1; res_valid stays 0.
- Simultaneous case: tags 0 and 1 outstanding with res_ready=0, tag1 answered in the same cycle tag0 expires -> tag1 result pushed first, tag0 timeout pushed next cycle; buffer holds 2; cmd_ready held 0 until pops bring (outstanding+count)<4.
- Reset asserted during OP1 -> req_cmd_out/req_data_out/req_tag_out = 0 without waiting for a clock edge; outstanding=0; after release, a new op gets tag 0.
